// File: rtl/des_keysched_3_if.sv
// Handshake bundle between a DES key-schedule generator and its subkey consumer.
interface des_keysched_3_if #(
  parameter int NUM_KEYS = 1
);
  logic                    start;
  logic                    decrypt;
  logic [64*NUM_KEYS-1:0]  key;
  logic                    abort;
  logic                    ready;
  logic                    busy;
  logic [47:0]             round_key;
  logic                    rk_valid;
  logic                    rk_ready;
  logic [3:0]              round_idx;
  logic [1:0]              pass_idx;
  logic                    last;
  logic                    done;

  modport master (
    output start, decrypt, key, abort, rk_ready,
    input  ready, busy, round_key, rk_valid, round_idx, pass_idx, last, done
  );

  modport slave (
    input  start, decrypt, key, abort, rk_ready,
    output ready, busy, round_key, rk_valid, round_idx, pass_idx, last, done
  );
endinterface

// File: rtl/des_keysched_3.sv
// DES / 3DES round-key generator. Streams 16 PC-2 subkeys per pass over a
// valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order,
// rotating C/D on every accepted subkey and reloading them at pass boundaries.
module des_keysched_3 #(
  parameter int NUM_KEYS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  des_keysched_3_if.slave bus
);

  localparam int         PASSES    = (NUM_KEYS == 1) ? 1 : 3;
  localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

  // DES bit numbers: bit 1 is the MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r = {r[54:0], k[6'(64 - PC1_TAB[i])]};
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r = {r[46:0], cd[6'(56 - PC2_TAB[i])]};
    return r;
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // Rounds 1, 2, 9 and 16 (zero-based 0, 1, 8, 15) shift by one, others by two.
  function automatic logic shift_one(input logic [3:0] r);
    return (r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15);
  endfunction

  // Encrypt order walks k1,k2,k3; decrypt order walks k3,k2,k1.
  function automatic logic [63:0] pass_key(input logic [191:0] kv, input logic dec,
                                           input logic [1:0] p);
    logic [1:0] slot;
    slot = dec ? (2'd2 - p) : p;
    case (slot)
      2'd0:    return kv[63:0];
      2'd1:    return kv[127:64];
      default: return kv[191:128];
    endcase
  endfunction

  // Middle pass runs opposite to the outer ones (EDE / DED).
  function automatic logic pass_dir_d(input logic dec, input logic [1:0] p);
    return dec ^ (p == 2'd1);
  endfunction

  // Encrypt passes start pre-rotated by one so the first subkey is K1;
  // decrypt passes start unrotated, which is K16 (total rotation of 28).
  function automatic logic [55:0] prep(input logic [63:0] k, input logic dir_d);
    logic [55:0] cd;
    cd = pc1(k);
    if (!dir_d) cd = {rol28(cd[55:28], 1'b1), rol28(cd[27:0], 1'b1)};
    return cd;
  endfunction

  state_t                 state;
  logic                   ready_q;
  logic                   busy_q;
  logic                   valid_q;
  logic                   done_q;
  logic [64*NUM_KEYS-1:0] key_q;
  logic                   dec_q;
  logic [27:0]            c_q;
  logic [27:0]            d_q;
  logic [3:0]             step_q;
  logic [1:0]             pass_q;

  // Every mode is widened to three key slots; missing slots alias k1, which
  // also gives the k3 = k1 behaviour of 2-key 3DES.
  logic [191:0] key_in_ext;
  logic [191:0] key_q_ext;

  if (NUM_KEYS == 1) begin : g_one_key
    assign key_in_ext = {3{bus.key[63:0]}};
    assign key_q_ext  = {3{key_q[63:0]}};
  end else if (NUM_KEYS == 2) begin : g_two_keys
    assign key_in_ext = {bus.key[63:0], bus.key};
    assign key_q_ext  = {key_q[63:0], key_q};
  end else if (NUM_KEYS == 3) begin : g_three_keys
    assign key_in_ext = bus.key;
    assign key_q_ext  = key_q;
  end else begin : g_bad_num_keys
    $error("des_keysched_3: NUM_KEYS must be 1, 2 or 3");
    assign key_in_ext = '0;
    assign key_q_ext  = '0;
  end

  logic        dir_d;
  logic [3:0]  ridx;
  logic        hs;
  logic        end_of_pass;
  logic [1:0]  next_pass;
  logic [55:0] first_cd;
  logic [55:0] next_pass_cd;
  logic [55:0] step_cd;

  assign dir_d        = pass_dir_d(dec_q, pass_q);
  assign ridx         = dir_d ? ~step_q : step_q;
  assign hs           = valid_q && bus.rk_ready;
  assign end_of_pass  = (step_q == 4'd15);
  assign next_pass    = pass_q + 2'd1;
  assign first_cd     = prep(pass_key(key_in_ext, bus.decrypt, 2'd0), bus.decrypt);
  assign next_pass_cd = prep(pass_key(key_q_ext, dec_q, next_pass),
                             pass_dir_d(dec_q, next_pass));
  assign step_cd      = dir_d ?
      {ror28(c_q, shift_one(ridx)), ror28(d_q, shift_one(ridx))} :
      {rol28(c_q, shift_one(ridx + 4'd1)), rol28(d_q, shift_one(ridx + 4'd1))};

  // Control FSM plus key/C/D state; all handshake outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      pass_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            state   <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            key_q   <= bus.key;
            dec_q   <= bus.decrypt;
            {c_q, d_q} <= first_cd;
            step_q  <= '0;
            pass_q  <= '0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (hs) begin
            if (end_of_pass && pass_q == LAST_PASS) begin
              state   <= DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (end_of_pass) begin
              pass_q     <= next_pass;
              step_q     <= '0;
              {c_q, d_q} <= next_pass_cd;
            end else begin
              step_q     <= step_q + 4'd1;
              {c_q, d_q} <= step_cd;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rk_valid  = valid_q;
  assign bus.done      = done_q;
  assign bus.round_key = pc2({c_q, d_q});
  assign bus.round_idx = ridx;
  assign bus.pass_idx  = pass_q;
  assign bus.last      = valid_q && (pass_q == LAST_PASS) && end_of_pass;

endmodule

// File: tb/tb_des_keysched_3.sv
// Directed bench for des_keysched_3: single DES (NUM_KEYS=1) and 3-key 3DES
// (NUM_KEYS=3) instances share one clock and reset.
module tb_des_keysched_3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_keysched_3_if #(.NUM_KEYS(1)) if1 ();
  des_keysched_3_if #(.NUM_KEYS(3)) if3 ();

  des_keysched_3 #(.NUM_KEYS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  des_keysched_3 #(.NUM_KEYS(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  // Subkeys K1..K16 of the classic worked example key above.
  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  int checks = 0;
  int errors = 0;

  task automatic test_reset;
    rst_n = 1'b0;
    if1.start = 0; if1.decrypt = 0; if1.key = '0; if1.abort = 0; if1.rk_ready = 0;
    if3.start = 0; if3.decrypt = 0; if3.key = '0; if3.abort = 0; if3.rk_ready = 0;
    repeat (3) @(negedge clk);
    checks++; if (if1.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", if1.ready); end
    checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", if1.busy); end
    checks++; if (if1.rk_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if1.rk_valid); end
    checks++; if (if1.last !== 1'b0 || if1.done !== 1'b0) begin errors++; $display("FAIL rst_last_done got %b%b exp 00", if1.last, if1.done); end
    checks++; if (if1.round_key !== 48'h0) begin errors++; $display("FAIL rst_round_key got %h exp 0", if1.round_key); end
    checks++; if (if1.round_idx !== 4'd0 || if1.pass_idx !== 2'd0) begin errors++; $display("FAIL rst_idx got %0d/%0d exp 0/0", if1.round_idx, if1.pass_idx); end
    checks++; if (if3.ready !== 1'b1 || if3.rk_valid !== 1'b0 || if3.round_key !== 48'h0) begin errors++; $display("FAIL rst3 got ready %b valid %b rk %h exp 1 0 0", if3.ready, if3.rk_valid, if3.round_key); end
    rst_n = 1'b1;
  endtask

  // Single DES, rk_ready always high: 16 back-to-back subkeys then done.
  task automatic test_single_des(input logic dec);
    int e;
    @(negedge clk);
    if1.key = KEY; if1.decrypt = dec; if1.rk_ready = 1; if1.start = 1;
    @(negedge clk);
    if1.start = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      e = dec ? 15 - i : i;
      checks++; if (if1.rk_valid !== 1'b1 || if1.busy !== 1'b1 || if1.ready !== 1'b0) begin errors++; $display("FAIL single_flags dec=%0d i=%0d got v%b b%b r%b exp 1 1 0", dec, i, if1.rk_valid, if1.busy, if1.ready); end
      checks++; if (if1.round_key !== ks[e]) begin errors++; $display("FAIL single_key dec=%0d i=%0d got %h exp %h", dec, i, if1.round_key, ks[e]); end
      checks++; if (if1.round_idx !== 4'(e) || if1.pass_idx !== 2'd0) begin errors++; $display("FAIL single_idx dec=%0d i=%0d got %0d/%0d exp %0d/0", dec, i, if1.round_idx, if1.pass_idx, e); end
      checks++; if (if1.last !== (i == 15)) begin errors++; $display("FAIL single_last dec=%0d i=%0d got %b exp %b", dec, i, if1.last, (i == 15)); end
      checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL single_early_done dec=%0d i=%0d got %b exp 0", dec, i, if1.done); end
    end
    @(negedge clk);
    checks++; if (if1.done !== 1'b1 || if1.rk_valid !== 1'b0 || if1.busy !== 1'b0) begin errors++; $display("FAIL single_done dec=%0d got d%b v%b b%b exp 1 0 0", dec, if1.done, if1.rk_valid, if1.busy); end
    @(negedge clk);
    checks++; if (if1.done !== 1'b0 || if1.ready !== 1'b1) begin errors++; $display("FAIL single_idle dec=%0d got d%b r%b exp 0 1", dec, if1.done, if1.ready); end
  endtask

  // 3-key 3DES; mask selects which slots hold KEY (others are all-zero,
  // whose subkeys are all zero), exposing both pass order and direction.
  task automatic test_3des(input logic [2:0] mask, input logic dec);
    int p, s, slot, ri;
    logic dd;
    logic [47:0] exp_k;
    @(negedge clk);
    if3.key = {mask[2] ? KEY : 64'h0, mask[1] ? KEY : 64'h0, mask[0] ? KEY : 64'h0};
    if3.decrypt = dec; if3.rk_ready = 1; if3.start = 1;
    @(negedge clk);
    if3.start = 0;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      p = i / 16; s = i % 16;
      slot = dec ? 2 - p : p;
      dd = dec ^ (p == 1);
      ri = dd ? 15 - s : s;
      exp_k = mask[slot] ? ks[ri] : 48'h0;
      checks++; if (if3.rk_valid !== 1'b1 || if3.round_key !== exp_k) begin errors++; $display("FAIL 3des_key m=%b dec=%0d i=%0d got v%b %h exp 1 %h", mask, dec, i, if3.rk_valid, if3.round_key, exp_k); end
      checks++; if (if3.round_idx !== 4'(ri) || if3.pass_idx !== 2'(p)) begin errors++; $display("FAIL 3des_idx m=%b dec=%0d i=%0d got %0d/%0d exp %0d/%0d", mask, dec, i, if3.round_idx, if3.pass_idx, ri, p); end
      checks++; if (if3.last !== (i == 47)) begin errors++; $display("FAIL 3des_last m=%b i=%0d got %b exp %b", mask, i, if3.last, (i == 47)); end
    end
    @(negedge clk);
    checks++; if (if3.done !== 1'b1 || if3.rk_valid !== 1'b0) begin errors++; $display("FAIL 3des_done m=%b got d%b v%b exp 1 0", mask, if3.done, if3.rk_valid); end
    @(negedge clk);
  endtask

  // Random consumer stalls; expected subkey only advances on a handshake.
  task automatic test_stall;
    int n, cyc;
    logic rr;
    @(negedge clk);
    if1.key = KEY; if1.decrypt = 0; if1.rk_ready = 0; if1.start = 1;
    @(negedge clk);
    if1.start = 0;
    n = 0; cyc = 0;
    while (n < 16 && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      checks++; if (if1.rk_valid !== 1'b1 || if1.round_key !== ks[n] || if1.round_idx !== 4'(n)) begin errors++; $display("FAIL stall_key n=%0d got v%b %h idx %0d exp 1 %h idx %0d", n, if1.rk_valid, if1.round_key, if1.round_idx, ks[n], n); end
      checks++; if (if1.last !== (n == 15) || if1.done !== 1'b0) begin errors++; $display("FAIL stall_last_done n=%0d got l%b d%b exp %b 0", n, if1.last, if1.done, (n == 15)); end
      rr = 1'($urandom_range(0, 1));
      if1.rk_ready = rr;
      if (rr) n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL stall_budget got %0d handshakes exp 16", n); end
    @(negedge clk);
    if1.rk_ready = 1;
    checks++; if (if1.done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", if1.done); end
    @(negedge clk);
  endtask

  // start and abort together in IDLE: nothing starts.
  task automatic test_start_abort_idle;
    @(negedge clk);
    if1.key = KEY; if1.decrypt = 0; if1.start = 1; if1.abort = 1;
    @(negedge clk);
    if1.start = 0; if1.abort = 0;
    checks++; if (if1.ready !== 1'b1 || if1.rk_valid !== 1'b0 || if1.busy !== 1'b0) begin errors++; $display("FAIL start_abort got r%b v%b b%b exp 1 0 0", if1.ready, if1.rk_valid, if1.busy); end
  endtask

  // Abort on the seventh subkey, then an all-zero key run.
  task automatic test_abort;
    @(negedge clk);
    if1.key = KEY; if1.decrypt = 0; if1.rk_ready = 1; if1.start = 1;
    @(negedge clk);
    if1.start = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (if1.round_key !== ks[i]) begin errors++; $display("FAIL abort_pre i=%0d got %h exp %h", i, if1.round_key, ks[i]); end
    end
    if1.abort = 1;
    @(negedge clk);
    if1.abort = 0;
    checks++; if (if1.ready !== 1'b1 || if1.rk_valid !== 1'b0 || if1.done !== 1'b0) begin errors++; $display("FAIL abort_idle got r%b v%b d%b exp 1 0 0", if1.ready, if1.rk_valid, if1.done); end
    if1.key = 64'h0; if1.start = 1;
    @(negedge clk);
    if1.start = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (if1.rk_valid !== 1'b1 || if1.round_key !== 48'h0 || if1.round_idx !== 4'(i) || if1.done !== 1'b0) begin errors++; $display("FAIL abort_zero i=%0d got v%b %h idx %0d d%b exp 1 0 %0d 0", i, if1.rk_valid, if1.round_key, if1.round_idx, if1.done, i); end
    end
    @(negedge clk);
    checks++; if (if1.done !== 1'b1) begin errors++; $display("FAIL abort_zero_done got %b exp 1", if1.done); end
    @(negedge clk);
  endtask

  // Held start is ignored while busy; asynchronous reset mid-run; restart on
  // the first edge after release.
  task automatic test_reset_midrun;
    @(negedge clk);
    if1.key = KEY; if1.decrypt = 0; if1.rk_ready = 1; if1.start = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (if1.round_key !== ks[i] || if1.round_idx !== 4'(i) || if1.ready !== 1'b0) begin errors++; $display("FAIL held_start i=%0d got %h idx %0d r%b exp %h idx %0d r0", i, if1.round_key, if1.round_idx, if1.ready, ks[i], i); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if1.ready !== 1'b1 || if1.busy !== 1'b0 || if1.rk_valid !== 1'b0) begin errors++; $display("FAIL async_rst_flags got r%b b%b v%b exp 1 0 0", if1.ready, if1.busy, if1.rk_valid); end
    checks++; if (if1.round_key !== 48'h0 || if1.round_idx !== 4'd0 || if1.last !== 1'b0 || if1.done !== 1'b0) begin errors++; $display("FAIL async_rst_data got %h idx %0d l%b d%b exp 0 0 0 0", if1.round_key, if1.round_idx, if1.last, if1.done); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (if1.rk_valid !== 1'b1 || if1.round_key !== ks[0] || if1.round_idx !== 4'd0) begin errors++; $display("FAIL restart got v%b %h idx %0d exp 1 %h 0", if1.rk_valid, if1.round_key, if1.round_idx, ks[0]); end
    if1.start = 0; if1.abort = 1;
    @(negedge clk);
    if1.abort = 0;
    checks++; if (if1.ready !== 1'b1 || if1.done !== 1'b0) begin errors++; $display("FAIL final_abort got r%b d%b exp 1 0", if1.ready, if1.done); end
  endtask

  initial begin
    test_reset();
    test_single_des(1'b0);
    test_single_des(1'b1);
    test_3des(3'b111, 1'b0);
    test_3des(3'b001, 1'b0);
    test_3des(3'b001, 1'b1);
    test_stall();
    test_start_abort_idle();
    test_abort();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
